lsu_mem_stage: RTL and testbench
================================

// Module: lsu_mem_stage
// PURPOSE
//  Memory stage for single data transfer (SDT) LDR/STR/LDRB/STRB instructions.
//  Takes the ALU's 33-bit adder_result as the effective (pre-indexed) address and
//  runs one data-memory transaction over a req/ack handshake.
//  Returns the aligned load data and the base-register writeback value.
//  Holds the pipeline with a stall until the transaction completes or times out.
// PARAMETERS
//  TIMEOUT   255  max cycles mem_req may wait for mem_ack before abort (1..255)
// PORTS
//  clk              in   1   clock, rising edge
//  nreset           in   1   async reset, active low
//  in_valid         in   1   execute-stage instruction valid
//  in_inst          in   32  instruction word
//  in_addr          in   33  ALU adder_result: base +/- offset; bit 32 ignored
//  in_base          in   32  unmodified base (Rn) value, used for post-index
//  in_store_data    in   32  Rd value for stores
//  stall            out  1   hold upstream pipeline
//  mem_req          out  1   memory request
//  mem_we           out  1   1=write, 0=read
//  mem_addr         out  32  word-aligned address {ea[31:2],2'b00}
//  mem_wdata        out  32  store data
//  mem_be           out  4   byte enables
//  mem_ack          in   1   memory accepted/completed request this cycle
//  mem_rdata        in   32  read data, valid when mem_ack=1
//  out_valid        out  1   one-cycle completion pulse
//  out_rd_we        out  1   load result write enable (qualified by out_valid)
//  out_rd           out  4   destination register inst[15:12]
//  out_rd_data      out  32  load result
//  out_rn_we        out  1   base writeback enable (qualified by out_valid)
//  out_rn           out  4   base register inst[19:16]
//  out_rn_data      out  32  in_addr[31:0] as captured
//  abort            out  1   one-cycle pulse on timeout
// BEHAVIOUR
//  - Reset: all outputs 0, state IDLE, timeout counter 0; async reset mid-transaction
//    drops mem_req immediately, nothing written back, no abort pulse.
//  - SDT decode: inst[27:26]==2'b01. Fields: P=inst[24] B=inst[22] W=inst[21] L=inst[20].
//  - Effective address: ea = P ? in_addr[31:0] : in_base.
//    Base writeback when (!P) || W.
//  - Non-SDT or in_valid=0: ignored; no stall, no outputs.
//  - FSM IDLE: on in_valid&&SDT, capture inst, ea, in_addr[31:0], store data; go REQ.
//    stall is combinationally 1 in this cycle.
//  - FSM REQ: mem_req=1; mem_we, mem_addr, mem_wdata, mem_be are held stable until ack.
//    On mem_ack: capture rdata and go RESP. Otherwise counter++.
//    When counter reaches TIMEOUT-1 without ack: go ABORT.
//  - FSM RESP: out_valid=1 for one cycle, with out_rd_we=L and out_rn_we=(!P||W).
//    If L and Rn==Rd, out_rn_we=0 (load wins). stall=0 in this cycle. Next state IDLE.
//  - FSM ABORT: abort=1 and out_valid=0 for one cycle; stall=0; next state IDLE.
//  - stall = (state==IDLE && in_valid && SDT) || state==REQ.
//  - Latency: accept at cycle N, req from N+1, ack at N+1+k, out_valid at N+2+k.
//    Minimum 3 cycles from accept to completion.
//  - Byte store: wdata = {4{data[7:0]}}, be = 4'b0001<<ea[1:0].
//    Word store: wdata = data, be = 4'hF.
//  - Byte load: zero-extended lane ea[1:0] of rdata.
//    Word load: rdata rotated right by 8*ea[1:0].
//  - mem_ack outside REQ is ignored. A new instruction is accepted only in IDLE.
//    No back-to-back accept from RESP or ABORT.
// TESTING
//  - LDR P=1 W=0, in_addr=0x100, ack after 2 cycles, rdata=0xDEADBEEF ->
//    mem_addr=0x100, be=F; out_rd_data=0xDEADBEEF, out_rd_we=1, out_rn_we=0; stall for 4 cycles.
//  - STRB P=1, in_addr=0x203, data=0x123456AB, ack same cycle as req ->
//    wdata=0xABABABAB, be=4'b1000, mem_addr=0x200, out_valid 1 cycle, no writes enabled.
//  - LDR post-index (P=0), in_base=0x40, in_addr=0x44, rdata=0x11223344 ->
//    mem_addr=0x40, out_rn_data=0x44, out_rn_we=1, out_rd_we=1.
//  - Unaligned LDR, ea=0x1002, rdata=0x11223344 -> out_rd_data=0x33441122.
//  - No ack, TIMEOUT=4 -> mem_req high 4 cycles, abort pulse, out_valid=0, stall released.
//  - nreset low during REQ -> mem_req=0 immediately; after release, idle and accepts a new LDR.

Source files
------------

// File: rtl/lsu_mem_stage.sv
// Memory stage for LDR/STR/LDRB/STRB: one req/ack data-memory transaction per
// accepted instruction, with load alignment, base writeback and timeout abort.
module lsu_mem_stage #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        nreset,
    input  logic        in_valid,
    input  logic [31:0] in_inst,
    input  logic [32:0] in_addr,
    input  logic [31:0] in_base,
    input  logic [31:0] in_store_data,
    output logic        stall,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        out_valid,
    output logic        out_rd_we,
    output logic [3:0]  out_rd,
    output logic [31:0] out_rd_data,
    output logic        out_rn_we,
    output logic [3:0]  out_rn,
    output logic [31:0] out_rn_data,
    output logic        abort
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        RESP  = 2'd2,
        ABORT = 2'd3
    } state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [7:0]  r_cnt;
    logic [7:0]  w_cnt_nxt;

    logic        r_we;
    logic        r_byte;
    logic [1:0]  r_lane;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_be;
    logic [3:0]  r_rd;
    logic [3:0]  r_rn;
    logic        r_rd_we;
    logic        r_rn_we;
    logic [31:0] r_rn_data;
    logic [31:0] r_rd_data;

    logic        w_is_sdt;
    logic        w_accept;
    logic        w_p;
    logic        w_b;
    logic        w_w;
    logic        w_l;
    logic [31:0] w_ea;
    logic [31:0] w_st_wdata;
    logic [3:0]  w_st_be;
    logic        w_in_req;
    logic        w_unused;

    // Byte loads take one zero-extended lane; word loads rotate the word so
    // the addressed byte lands in bits [7:0].
    function automatic logic [31:0] load_align(input logic [31:0] data,
                                               input logic [1:0]  lane,
                                               input logic        is_byte);
        logic [31:0] rot;
        case (lane)
            2'd0:    rot = data;
            2'd1:    rot = {data[7:0],  data[31:8]};
            2'd2:    rot = {data[15:0], data[31:16]};
            default: rot = {data[23:0], data[31:24]};
        endcase
        return is_byte ? {24'd0, rot[7:0]} : rot;
    endfunction

    assign w_is_sdt   = (in_inst[27:26] == 2'b01);
    assign w_p        = in_inst[24];
    assign w_b        = in_inst[22];
    assign w_w        = in_inst[21];
    assign w_l        = in_inst[20];
    assign w_accept   = (r_state == IDLE) && in_valid && w_is_sdt;
    assign w_ea       = w_p ? in_addr[31:0] : in_base;
    assign w_st_wdata = w_b ? {4{in_store_data[7:0]}} : in_store_data;
    assign w_st_be    = w_b ? (4'b0001 << w_ea[1:0]) : 4'hF;
    assign w_unused   = ^{in_addr[32], in_inst[31:28], in_inst[25], in_inst[23], in_inst[11:0]};

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_nxt = REQ;
                    w_cnt_nxt   = 8'd0;
                end
            end
            REQ: begin
                if (mem_ack) begin
                    w_state_nxt = RESP;
                    w_cnt_nxt   = 8'd0;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt = ABORT;
                    w_cnt_nxt   = 8'd0;
                end else begin
                    w_cnt_nxt   = r_cnt + 8'd1;
                end
            end
            RESP:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_state <= IDLE;
            r_cnt   <= 8'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Transaction capture at accept; load data aligned as it arrives.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_we      <= 1'b0;
            r_byte    <= 1'b0;
            r_lane    <= 2'd0;
            r_addr    <= 32'd0;
            r_wdata   <= 32'd0;
            r_be      <= 4'd0;
            r_rd      <= 4'd0;
            r_rn      <= 4'd0;
            r_rd_we   <= 1'b0;
            r_rn_we   <= 1'b0;
            r_rn_data <= 32'd0;
            r_rd_data <= 32'd0;
        end else begin
            if (w_accept) begin
                r_we      <= !w_l;
                r_byte    <= w_b;
                r_lane    <= w_ea[1:0];
                r_addr    <= {w_ea[31:2], 2'b00};
                r_wdata   <= w_st_wdata;
                r_be      <= w_st_be;
                r_rd      <= in_inst[15:12];
                r_rn      <= in_inst[19:16];
                r_rd_we   <= w_l;
                r_rn_we   <= (!w_p || w_w) && !(w_l && (in_inst[19:16] == in_inst[15:12]));
                r_rn_data <= in_addr[31:0];
            end
            if ((r_state == REQ) && mem_ack) begin
                r_rd_data <= load_align(mem_rdata, r_lane, r_byte);
            end
        end
    end

    assign w_in_req    = (r_state == REQ);
    assign stall       = w_accept || w_in_req;
    assign mem_req     = w_in_req;
    assign mem_we      = w_in_req & r_we;
    assign mem_addr    = w_in_req ? r_addr  : 32'd0;
    assign mem_wdata   = w_in_req ? r_wdata : 32'd0;
    assign mem_be      = w_in_req ? r_be    : 4'd0;

    assign out_valid   = (r_state == RESP);
    assign out_rd_we   = out_valid & r_rd_we;
    assign out_rn_we   = out_valid & r_rn_we;
    assign out_rd      = r_rd;
    assign out_rn      = r_rn;
    assign out_rd_data = r_rd_data;
    assign out_rn_data = r_rn_data;
    assign abort       = (r_state == ABORT);

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Directed bench for lsu_mem_stage: vector table of SDT transactions plus
// hand-written timeout, ignore and asynchronous-reset sequences.
module tb_lsu_mem_stage;

    logic        clk = 1'b0;
    logic        nreset;
    logic        in_valid;
    logic [31:0] in_inst;
    logic [32:0] in_addr;
    logic [31:0] in_base;
    logic [31:0] in_store_data;
    logic        stall;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        out_valid;
    logic        out_rd_we;
    logic [3:0]  out_rd;
    logic [31:0] out_rd_data;
    logic        out_rn_we;
    logic [3:0]  out_rn;
    logic [31:0] out_rn_data;
    logic        abort;

    int total = 0;
    int bad   = 0;

    lsu_mem_stage #(.TIMEOUT(4)) dut (
        .clk(clk), .nreset(nreset), .in_valid(in_valid), .in_inst(in_inst),
        .in_addr(in_addr), .in_base(in_base), .in_store_data(in_store_data),
        .stall(stall), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .out_valid(out_valid), .out_rd_we(out_rd_we), .out_rd(out_rd),
        .out_rd_data(out_rd_data), .out_rn_we(out_rn_we), .out_rn(out_rn),
        .out_rn_data(out_rn_data), .abort(abort)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] inst;
        logic [32:0] addr;
        logic [31:0] base;
        logic [31:0] sdata;
        logic [31:0] rdata;
        int          dly;
        logic        e_we;
        logic [31:0] e_addr;
        logic [31:0] e_wdata;
        logic [3:0]  e_be;
        logic        c_wd;
        logic        c_be;
        logic        e_rd_we;
        logic        e_rn_we;
        logic [3:0]  e_rd;
        logic [3:0]  e_rn;
        logic [31:0] e_rd_data;
        logic [31:0] e_rn_data;
    } vec_t;

    vec_t tbl [8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int stalls;
        stalls = 0;
        @(negedge clk);
        in_valid = 1'b1; in_inst = v.inst; in_addr = v.addr; in_base = v.base;
        in_store_data = v.sdata; mem_ack = 1'b0;
        #1;
        if (stall) stalls++;
        chk($sformatf("v%0d idle_req", idx), 32'(mem_req), 0);
        for (int j = 0; j <= v.dly; j++) begin
            @(negedge clk);
            in_valid  = 1'b0;
            mem_ack   = (j == v.dly);
            mem_rdata = (j == v.dly) ? v.rdata : 32'h0BAD_F00D;
            #1;
            if (stall) stalls++;
            chk($sformatf("v%0d req%0d", idx, j), 32'(mem_req), 1);
            chk($sformatf("v%0d addr%0d", idx, j), mem_addr, v.e_addr);
            chk($sformatf("v%0d we%0d", idx, j), 32'(mem_we), 32'(v.e_we));
            if (v.c_be) chk($sformatf("v%0d be%0d", idx, j), 32'(mem_be), 32'(v.e_be));
            if (v.c_wd) chk($sformatf("v%0d wdata%0d", idx, j), mem_wdata, v.e_wdata);
        end
        @(negedge clk);
        mem_ack = 1'b0;
        #1;
        chk($sformatf("v%0d out_valid", idx), 32'(out_valid), 1);
        chk($sformatf("v%0d resp_stall", idx), 32'(stall), 0);
        chk($sformatf("v%0d resp_req", idx), 32'(mem_req), 0);
        chk($sformatf("v%0d abort", idx), 32'(abort), 0);
        chk($sformatf("v%0d rd_we", idx), 32'(out_rd_we), 32'(v.e_rd_we));
        chk($sformatf("v%0d rn_we", idx), 32'(out_rn_we), 32'(v.e_rn_we));
        chk($sformatf("v%0d rd", idx), 32'(out_rd), 32'(v.e_rd));
        chk($sformatf("v%0d rn", idx), 32'(out_rn), 32'(v.e_rn));
        chk($sformatf("v%0d rn_data", idx), out_rn_data, v.e_rn_data);
        if (v.e_rd_we) chk($sformatf("v%0d rd_data", idx), out_rd_data, v.e_rd_data);
        chk($sformatf("v%0d stall_cycles", idx), stalls, v.dly + 2);
        @(negedge clk);
        #1;
        chk($sformatf("v%0d valid_pulse", idx), 32'(out_valid), 0);
    endtask

    initial begin
        // inst, addr, base, sdata, rdata, dly, we, maddr, wdata, be, c_wd, c_be, rd_we, rn_we, rd, rn, rd_data, rn_data
        tbl[0] = '{32'hE5912000, 33'h100, 32'hF0, 32'h0, 32'hDEADBEEF, 2,
                   1'b0, 32'h100, 32'h0, 4'hF, 1'b0, 1'b1, 1'b1, 1'b0, 4'd2, 4'd1, 32'hDEADBEEF, 32'h100};
        tbl[1] = '{32'hE5C34000, 33'h203, 32'h0, 32'h123456AB, 32'h0, 0,
                   1'b1, 32'h200, 32'hABABABAB, 4'b1000, 1'b1, 1'b1, 1'b0, 1'b0, 4'd4, 4'd3, 32'h0, 32'h203};
        tbl[2] = '{32'hE4956000, 33'h1_0000_0044, 32'h40, 32'h0, 32'h11223344, 1,
                   1'b0, 32'h40, 32'h0, 4'hF, 1'b0, 1'b1, 1'b1, 1'b1, 4'd6, 4'd5, 32'h11223344, 32'h44};
        tbl[3] = '{32'hE5978000, 33'h1002, 32'h0, 32'h0, 32'h11223344, 0,
                   1'b0, 32'h1000, 32'h0, 4'hF, 1'b0, 1'b1, 1'b1, 1'b0, 4'd8, 4'd7, 32'h33441122, 32'h1002};
        tbl[4] = '{32'hE5F9A000, 33'h301, 32'h0, 32'h0, 32'h11223344, 1,
                   1'b0, 32'h300, 32'h0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b1, 4'd10, 4'd9, 32'h00000033, 32'h301};
        tbl[5] = '{32'hE5B33000, 33'h500, 32'h0, 32'h0, 32'hCAFEF00D, 3,
                   1'b0, 32'h500, 32'h0, 4'hF, 1'b0, 1'b1, 1'b1, 1'b0, 4'd3, 4'd3, 32'hCAFEF00D, 32'h500};
        tbl[6] = '{32'hE4821000, 33'h804, 32'h800, 32'h89ABCDEF, 32'h0, 1,
                   1'b1, 32'h800, 32'h89ABCDEF, 4'hF, 1'b1, 1'b1, 1'b0, 1'b1, 4'd1, 4'd2, 32'h0, 32'h804};
        tbl[7] = '{32'hE5C45000, 33'h601, 32'h0, 32'h000000C3, 32'h0, 2,
                   1'b1, 32'h600, 32'hC3C3C3C3, 4'b0010, 1'b1, 1'b1, 1'b0, 1'b0, 4'd5, 4'd4, 32'h0, 32'h601};

        nreset = 1'b0; in_valid = 1'b0; in_inst = 32'h0; in_addr = 33'h0; in_base = 32'h0;
        in_store_data = 32'h0; mem_ack = 1'b0; mem_rdata = 32'h0;
        #12;
        chk("rst_ctrl", 32'({stall, mem_req, mem_we, out_valid, out_rd_we, out_rn_we, abort}), 0);
        chk("rst_maddr", mem_addr, 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_be", 32'(mem_be), 0);
        chk("rst_rd_data", out_rd_data, 0);
        chk("rst_rn_data", out_rn_data, 0);
        chk("rst_regs", 32'({out_rd, out_rn}), 0);
        @(negedge clk);
        nreset = 1'b1;

        for (int i = 0; i < 8; i++) run_vec(tbl[i], i);

        // Non-SDT instruction and invalid SDT are ignored
        @(negedge clk);
        in_valid = 1'b1; in_inst = 32'hE0812003; in_addr = 33'h100;
        #1;
        chk("nonsdt_stall", 32'(stall), 0);
        @(negedge clk);
        in_valid = 1'b0; in_inst = 32'hE5912000;
        #1;
        chk("nonsdt_req", 32'(mem_req), 0);
        chk("invalid_stall", 32'(stall), 0);
        @(negedge clk);
        #1;
        chk("invalid_req", 32'(mem_req), 0);

        // Timeout: no ack for TIMEOUT=4 request cycles
        @(negedge clk);
        in_valid = 1'b1; in_inst = 32'hE5912000; in_addr = 33'h700;
        #1;
        chk("to_accept_stall", 32'(stall), 1);
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            in_valid = 1'b0;
            #1;
            chk($sformatf("to_req%0d", j), 32'(mem_req), 1);
            chk($sformatf("to_stall%0d", j), 32'(stall), 1);
        end
        @(negedge clk);
        in_valid = 1'b1;
        #1;
        chk("to_abort", 32'(abort), 1);
        chk("to_out_valid", 32'(out_valid), 0);
        chk("to_stall_rel", 32'(stall), 0);
        chk("to_req_drop", 32'(mem_req), 0);
        @(negedge clk);
        in_valid = 1'b0; mem_ack = 1'b1;
        #1;
        chk("to_abort_pulse", 32'(abort), 0);
        chk("to_no_accept", 32'(mem_req), 0);
        @(negedge clk);
        mem_ack = 1'b0;
        #1;
        chk("idle_ack_ignored", 32'(out_valid), 0);

        // Asynchronous reset while requesting
        @(negedge clk);
        in_valid = 1'b1; in_inst = 32'hE5912000; in_addr = 33'h900;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        chk("ar_req_before", 32'(mem_req), 1);
        nreset = 1'b0;
        #1;
        chk("ar_req_drop", 32'(mem_req), 0);
        chk("ar_stall", 32'(stall), 0);
        for (int j = 0; j < 2; j++) begin
            @(negedge clk);
            #1;
            chk($sformatf("ar_quiet%0d", j), 32'({out_valid, abort, out_rd_we, out_rn_we}), 0);
        end
        @(negedge clk);
        nreset = 1'b1;
        #1;
        chk("ar_idle", 32'({stall, mem_req}), 0);
        run_vec(tbl[0], 8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
